// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a small
// byte FIFO with a valid/ready output stream and one-cycle error pulses.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int BIT_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(BIT_DIV - 1);
  localparam logic [AW:0]   FULL_C = (AW+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [1:0]    hist;
  logic          maj;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_ok;
  logic          stop_hit;
  logic          push;

  // Two-flop synchroniser, idle-high reset so no false start comes out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist   <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
      hist   <= {hist[0], rx_s};
    end
  end

  assign rx_s = sync_q[1];
  assign maj  = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;
  assign par_ok     = ~(^shreg ^ par_bit);
  assign parity_err = perr_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign stop_hit = (state == S_STOP) && (cnt == LAST_C);
  assign push     = stop_hit && maj && par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      cnt <= (cnt == LAST_C) ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (!maj) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (cnt == LAST_C) begin
            shreg[bit_idx] <= maj;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == LAST_C) begin
            par_bit <= maj;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (cnt == LAST_C) begin
            // a low stop bit wins over parity; the line may be in break
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (!par_ok) perr_q <= 1'b1;
`endif
              state <= S_IDLE;
            end
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              rd_ptr, wr_ptr;
  logic [AW:0]                count;
  logic                       pop, full, wr_en;

  assign valid = (count != '0);
  assign data  = mem[rd_ptr];
  assign pop   = valid && ready;
  assign full  = (count == FULL_C);
  // a pop in the same cycle frees the slot the push needs
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem     <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !wr_en;
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
